conv3x3_ctrl: RTL and testbench

Sequencer for the 3x3 convolution engine: loads the nine signed 8-bit weights, accepts a raster-order pixel stream of one IMG_W x IMG_H frame, builds the 3x3 window with two line buffers, and issues one window per valid output position (no padding, stride 1). It sits between the frame source and the convolution engine. It counts the engine's result strobes and raises `done` once the last result of the frame has emerged.

---
 rtl/conv_pkg.sv | 31 +++
 rtl/line_buffer.sv | 35 +++
 rtl/conv3x3_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_conv3x3_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and constants for the 3x3 convolution sequencer:
//               state encoding, default data width, tap count and helpers
//               for the window/weight bus width and output-position count.
// Revision    : 1.0  initial release
// ============================================================================
package conv_pkg;

    localparam int c_DW   = 8;   // default pixel / weight width
    localparam int c_TAPS = 9;   // taps in a 3x3 window

    typedef logic [1:0] state_t;
    localparam state_t c_ST_IDLE   = 2'd0;
    localparam state_t c_ST_LOAD_W = 2'd1;
    localparam state_t c_ST_STREAM = 2'd2;
    localparam state_t c_ST_DRAIN  = 2'd3;

    // Width of a packed 3x3 bus (window or weight file)
    function automatic int bus_w(input int dw);
        return c_TAPS * dw;
    endfunction

    // Number of valid output positions (no padding, stride 1)
    function automatic int calc_n(input int img_w, input int img_h);
        return (img_w - 2) * (img_h - 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer
// Description : Enable-gated shift register; dout is din delayed by exactly
//               DEPTH enabled cycles.
// Ports       : clk, rst (async, active high), en (shift enable),
//               din [DW-1:0], dout [DW-1:0]
// Revision    : 1.0  initial release
// ============================================================================
module line_buffer #(
    parameter int DEPTH = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    // Newest entry in the low slice, oldest in the high slice
    logic [DEPTH*DW-1:0] r_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (en) begin
            r_sr <= {r_sr[(DEPTH-1)*DW-1:0], din};
        end
    end

    assign dout = r_sr[DEPTH*DW-1 -: DW];

endmodule
`default_nettype wire

// File: rtl/conv3x3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_ctrl
// Description : Sequencer for the 3x3 convolution engine. Loads nine weights,
//               accepts one raster frame, builds 3x3 windows from two line
//               buffers and three column registers, and counts engine
//               results to signal end of frame.
// Ports       : clk, rst (async, active high)
//               start, reload_w           - frame launch control
//               w_valid/w_data/w_ready    - weight load handshake
//               pix_valid/pix_data/pix_ready - pixel stream handshake
//               win_valid/win_data        - window to engine
//               weights                   - held weight file
//               eng_valid                 - engine result strobe
//               busy, done                - status
// Revision    : 1.0  initial release
// ============================================================================
module conv3x3_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int DW    = c_DW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   reload_w,
    input  logic                   w_valid,
    input  logic [DW-1:0]          w_data,
    output logic                   w_ready,
    input  logic                   pix_valid,
    input  logic [DW-1:0]          pix_data,
    output logic                   pix_ready,
    output logic                   win_valid,
    output logic [bus_w(DW)-1:0]   win_data,
    output logic [bus_w(DW)-1:0]   weights,
    input  logic                   eng_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int c_CW = $clog2(IMG_W);
    localparam int c_RW = $clog2(IMG_H);
    localparam int c_N  = calc_n(IMG_W, IMG_H);
    localparam int c_NW = $clog2(c_N + 1);

    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
    localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);
    localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
    localparam logic [c_RW-1:0] c_ROW_TWO  = c_RW'(2);
    localparam logic [c_NW-1:0] c_N_CNT    = c_NW'(c_N);

    state_t              r_state;
    logic [3:0]          r_w_idx;
    logic [c_CW-1:0]     r_col;
    logic [c_RW-1:0]     r_row;
    logic [c_NW-1:0]     r_res_cnt;
    logic [3*DW-1:0]     r_top;   // slice 0 = oldest column
    logic [3*DW-1:0]     r_mid;
    logic [3*DW-1:0]     r_bot;

    logic                w_w_acc;
    logic                w_pix_acc;
    logic                w_res_inc;
    logic [c_NW-1:0]     w_res_next;
    logic [DW-1:0]       w_lb1_out;
    logic [DW-1:0]       w_lb2_out;

    assign w_w_acc    = w_valid & w_ready;
    assign w_pix_acc  = pix_valid & pix_ready;
    // Results only count while a frame is in flight, and saturate at N
    assign w_res_inc  = eng_valid
                      & ((r_state == c_ST_STREAM) | (r_state == c_ST_DRAIN))
                      & (r_res_cnt != c_N_CNT);
    assign w_res_next = r_res_cnt + c_NW'(w_res_inc);

    // Chained so the second buffer delivers the pixel two rows above
    line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (w_pix_acc),
        .din  (pix_data),
        .dout (w_lb1_out)
    );

    line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
        .clk  (clk),
        .rst  (rst),
        .en   (w_pix_acc),
        .din  (w_lb1_out),
        .dout (w_lb2_out)
    );

    // Control FSM, counters and weight file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_w_idx   <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_res_cnt <= '0;
            w_ready   <= 1'b0;
            pix_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            weights   <= '0;
        end else begin
            done <= 1'b0;
            if (w_res_inc) begin
                r_res_cnt <= w_res_next;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        r_res_cnt <= '0;
                        r_col     <= '0;
                        r_row     <= '0;
                        r_w_idx   <= '0;
                        if (reload_w) begin
                            r_state <= c_ST_LOAD_W;
                            w_ready <= 1'b1;
                        end else begin
                            r_state   <= c_ST_STREAM;
                            pix_ready <= 1'b1;
                        end
                    end
                end
                c_ST_LOAD_W: begin
                    if (w_w_acc) begin
                        weights[r_w_idx*DW +: DW] <= w_data;
                        if (r_w_idx == 4'd8) begin
                            r_w_idx   <= '0;
                            r_state   <= c_ST_STREAM;
                            w_ready   <= 1'b0;
                            pix_ready <= 1'b1;
                        end else begin
                            r_w_idx <= r_w_idx + 4'd1;
                        end
                    end
                end
                c_ST_STREAM: begin
                    if (w_pix_acc) begin
                        if (r_col == c_COL_LAST) begin
                            r_col <= '0;
                            if (r_row == c_ROW_LAST) begin
                                r_row     <= '0;
                                r_state   <= c_ST_DRAIN;
                                pix_ready <= 1'b0;
                            end else begin
                                r_row <= r_row + c_RW'(1);
                            end
                        end else begin
                            r_col <= r_col + c_CW'(1);
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_res_next == c_N_CNT) begin
                        r_state <= c_ST_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Window column registers; after an accept they hold the 3x3 window
    // ending at the accepted pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            r_top     <= '0;
            r_mid     <= '0;
            r_bot     <= '0;
        end else begin
            // Column >= 2 keeps windows from straddling a row boundary
            win_valid <= w_pix_acc & (r_row >= c_ROW_TWO) & (r_col >= c_COL_TWO);
            if (w_pix_acc) begin
                r_top <= {w_lb2_out, r_top[3*DW-1:DW]};
                r_mid <= {w_lb1_out, r_mid[3*DW-1:DW]};
                r_bot <= {pix_data,  r_bot[3*DW-1:DW]};
            end
        end
    end

    assign win_data = {r_bot, r_mid, r_top};

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv3x3_ctrl
// Description : Directed self-checking bench for conv3x3_ctrl on a 4x4 frame
//               with a two-cycle-latency engine valid model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_conv3x3_ctrl;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int DW    = 8;
    localparam int c_BW  = 9 * DW;

    logic            clk       = 1'b0;
    logic            rst       = 1'b1;
    logic            start     = 1'b0;
    logic            reload_w  = 1'b0;
    logic            w_valid   = 1'b0;
    logic [DW-1:0]   w_data    = '0;
    logic            pix_valid = 1'b0;
    logic [DW-1:0]   pix_data  = '0;
    logic            w_ready;
    logic            pix_ready;
    logic            win_valid;
    logic [c_BW-1:0] win_data;
    logic [c_BW-1:0] weights;
    logic            eng_valid;
    logic            busy;
    logic            done;

    logic            r_eng_d1;
    logic            r_eng_d2;

    int n_checks = 0;
    int n_pass   = 0;
    int n_eng    = 0;

    always #5 clk = ~clk;

    // Engine valid path: two-cycle latency from window to result
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_eng_d1 <= 1'b0;
            r_eng_d2 <= 1'b0;
        end else begin
            r_eng_d1 <= win_valid;
            r_eng_d2 <= r_eng_d1;
        end
    end
    assign eng_valid = r_eng_d2;

    conv3x3_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .reload_w  (reload_w),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .win_valid (win_valid),
        .win_data  (win_data),
        .weights   (weights),
        .eng_valid (eng_valid),
        .busy      (busy),
        .done      (done)
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({w_ready, pix_ready, win_valid, busy, done} !== 5'b00000)
            $display("FAIL reset_ctrl got %b exp 00000",
                     {w_ready, pix_ready, win_valid, busy, done});
        else n_pass++;
        n_checks++;
        if (win_data !== '0) $display("FAIL reset_win got %h exp 0", win_data);
        else n_pass++;
        n_checks++;
        if (weights !== '0) $display("FAIL reset_weights got %h exp 0", weights);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy);
        else n_pass++;
    endtask

    // ones=1 loads all-ones weights, otherwise weight k = k+1
    task automatic test_load_weights(input bit ones);
        logic [c_BW-1:0] exp_w;
        logic [DW-1:0]   wv;
        exp_w    = '0;
        start    = 1'b1;
        reload_w = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        reload_w = 1'b0;
        n_checks++;
        if ({w_ready, pix_ready, busy} !== 3'b101)
            $display("FAIL load_enter got %b exp 101", {w_ready, pix_ready, busy});
        else n_pass++;
        for (int k = 0; k < 9; k++) begin
            wv = ones ? 8'd1 : 8'(k + 1);
            exp_w[k*DW +: DW] = wv;
            w_valid = 1'b1;
            w_data  = wv;
            @(negedge clk);
            if (k < 8) begin
                n_checks++;
                if (w_ready !== 1'b1) $display("FAIL w_ready k=%0d got %b exp 1", k, w_ready);
                else n_pass++;
            end
        end
        w_valid = 1'b0;
        n_checks++;
        if ({w_ready, pix_ready} !== 2'b01)
            $display("FAIL load_exit got %b exp 01", {w_ready, pix_ready});
        else n_pass++;
        n_checks++;
        if (weights !== exp_w) $display("FAIL weights got %h exp %h", weights, exp_w);
        else n_pass++;
    endtask

    // Streams pixel 4r+c; toggle=1 drops pix_valid every other cycle
    task automatic test_stream(input bit toggle);
        int              p, cyc, nwin, r, c;
        bit              acc, exp_wv;
        logic [c_BW-1:0] exp_win;
        p = 0; cyc = 0; nwin = 0; n_eng = 0;
        while (p < IMG_W*IMG_H && cyc < 200) begin
            pix_valid = !toggle || (cyc % 2 == 0);
            pix_data  = 8'(p);
            acc       = pix_valid && pix_ready;
            r         = p / IMG_W;
            c         = p % IMG_W;
            exp_wv    = acc && r >= 2 && c >= 2;
            @(negedge clk);
            if (eng_valid) n_eng++;
            n_checks++;
            if (win_valid !== exp_wv)
                $display("FAIL win_valid p=%0d cyc=%0d got %b exp %b", p, cyc, win_valid, exp_wv);
            else n_pass++;
            if (exp_wv) begin
                nwin++;
                for (int k = 0; k < 9; k++)
                    exp_win[k*DW +: DW] = 8'((r - 2 + k/3) * IMG_W + (c - 2 + k%3));
                n_checks++;
                if (win_data !== exp_win)
                    $display("FAIL win_data p=%0d got %h exp %h", p, win_data, exp_win);
                else n_pass++;
            end
            if (acc) p++;
            cyc++;
        end
        pix_valid = 1'b0;
        n_checks++;
        if (p != IMG_W*IMG_H) $display("FAIL stream_timeout got %0d pixels exp %0d", p, IMG_W*IMG_H);
        else n_pass++;
        n_checks++;
        if (pix_ready !== 1'b0) $display("FAIL pix_ready_drop got %b exp 0", pix_ready);
        else n_pass++;
        n_checks++;
        if (nwin != 4) $display("FAIL win_count got %0d exp 4", nwin);
        else n_pass++;
    endtask

    task automatic test_done();
        int done_cnt;
        bit exp_done;
        done_cnt = 0;
        exp_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== exp_done) $display("FAIL done cyc=%0d got %b exp %b", i, done, exp_done);
            else n_pass++;
            if (done) begin
                done_cnt++;
                n_checks++;
                if (busy !== 1'b0) $display("FAIL busy_fall got %b exp 0", busy);
                else n_pass++;
            end
            if (eng_valid) begin
                n_eng++;
                exp_done = (n_eng == 4);
            end else begin
                exp_done = 1'b0;
            end
        end
        n_checks++;
        if (done_cnt != 1) $display("FAIL done_count got %0d exp 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (n_eng != 4) $display("FAIL eng_count got %0d exp 4", n_eng);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        test_load_weights(1'b0);
        test_stream(1'b0);
        test_done();
    endtask

    task automatic test_reuse_weights();
        logic [c_BW-1:0] exp_w;
        for (int k = 0; k < 9; k++) exp_w[k*DW +: DW] = 8'(k + 1);
        start    = 1'b1;
        reload_w = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({w_ready, pix_ready, busy} !== 3'b011)
            $display("FAIL reuse_enter got %b exp 011", {w_ready, pix_ready, busy});
        else n_pass++;
        n_checks++;
        if (weights !== exp_w) $display("FAIL reuse_weights got %h exp %h", weights, exp_w);
        else n_pass++;
        test_stream(1'b1);
        test_done();
    endtask

    task automatic test_reset_mid();
        start    = 1'b1;
        reload_w = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(k);
            @(negedge clk);
        end
        pix_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({w_ready, pix_ready, win_valid, busy, done} !== 5'b00000)
            $display("FAIL midrst_ctrl got %b exp 00000",
                     {w_ready, pix_ready, win_valid, busy, done});
        else n_pass++;
        n_checks++;
        if (weights !== '0) $display("FAIL midrst_weights got %h exp 0", weights);
        else n_pass++;
        n_checks++;
        if (win_data !== '0) $display("FAIL midrst_win got %h exp 0", win_data);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0) $display("FAIL midrst_done got %b exp 0", done);
            else n_pass++;
        end
        rst = 1'b0;
        @(negedge clk);
        test_load_weights(1'b1);
        test_stream(1'b0);
        test_done();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_reuse_weights();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
